// File: rtl/br_recovery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : br_recovery_pkg
// Brief    : Shared types and constants for the commit-time branch recovery
//            controller (state encoding, redirect payload, ROB sizing).
// Revision : 1.0 - initial release
// ============================================================================
package br_recovery_pkg;

    // Default ROB index width and the ROB depth it implies
    localparam int c_rob_idx_w_def = 5;
    localparam int c_rob_depth     = 1 << c_rob_idx_w_def;

    // Recovery controller states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } br_rec_state_t;

    // Payload handed to the frontend on a redirect
    typedef struct packed {
        logic [31:0] pc;
    } br_redirect_t;

endpackage : br_recovery_pkg
`default_nettype wire

// File: rtl/rob_age_cmp.sv
`default_nettype none
// ============================================================================
// Module   : rob_age_cmp
// Brief    : Combinational ROB age comparator. Age is the distance from the
//            current head modulo the ROB depth; a_older is set when a_id is
//            strictly older (closer to the head) than b_id.
// Revision : 1.0 - initial release
// ============================================================================
module rob_age_cmp #(
    parameter int ROB_IDX_W = 5
) (
    input  logic [ROB_IDX_W-1:0] a_id,
    input  logic [ROB_IDX_W-1:0] b_id,
    input  logic [ROB_IDX_W-1:0] head_id,
    output logic                 a_older
);

    logic [ROB_IDX_W-1:0] w_a_age;
    logic [ROB_IDX_W-1:0] w_b_age;

    // Wrap-around subtraction at ROB_IDX_W bits gives the age directly
    always_comb begin
        w_a_age = a_id - head_id;
        w_b_age = b_id - head_id;
        a_older = (w_a_age < w_b_age);
    end

endmodule : rob_age_cmp
`default_nettype wire

// File: rtl/br_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : br_recovery_ctrl
// Brief    : Commit-time branch recovery controller. Tracks the oldest
//            in-flight mispredicted branch, waits for it to commit, then
//            pulses a backend flush and offers the corrected PC to fetch over
//            a valid/ready redirect handshake.
// Revision : 1.0 - initial release
// ============================================================================
module br_recovery_ctrl
    import br_recovery_pkg::*;
#(
    parameter int ROB_IDX_W = c_rob_idx_w_def
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_valid,
    input  logic [ROB_IDX_W-1:0] br_rob_id,
    input  logic                 br_miss_predict,
    input  logic [31:0]          br_target_address,
    input  logic [ROB_IDX_W-1:0] rob_head_id,
    input  logic                 rob_commit,
    output logic                 flush,
    output logic                 busy,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic [31:0]          perf_br_cnt,
    output logic [31:0]          perf_mispredict_cnt
);

    br_rec_state_t        r_state;
    br_rec_state_t        w_state_nxt;
    logic [ROB_IDX_W-1:0] r_pend_rob_id;
    br_redirect_t         r_pend;
    br_redirect_t         r_redirect;

    logic w_new_older;
    logic w_commit_hit;
    logic w_br_mispredict;
    logic w_br_accept;
    logic w_capture;
    logic w_flush_nxt;
    logic w_busy_nxt;
    logic w_redirect_valid_nxt;

    // Is the incoming mispredict strictly older than the one already held?
    rob_age_cmp #(
        .ROB_IDX_W (ROB_IDX_W)
    ) u_age_cmp (
        .a_id    (br_rob_id),
        .b_id    (r_pend_rob_id),
        .head_id (rob_head_id),
        .a_older (w_new_older)
    );

    assign w_commit_hit    = rob_commit && (rob_head_id == r_pend_rob_id);
    assign w_br_mispredict = br_valid && br_miss_predict;
    // Branch results arriving during FLUSH/REDIRECT are wrong-path
    assign w_br_accept     = br_valid && ((r_state == ST_IDLE) || (r_state == ST_PENDING));
    assign redirect_pc     = r_redirect.pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pending-capture decision
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_br_mispredict) begin
                    w_state_nxt = ST_PENDING;
                    w_capture   = 1'b1;
                end
            end
            ST_PENDING: begin
                // A matching commit wins; any same-cycle branch result is dropped
                if (w_commit_hit) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_br_mispredict && w_new_older) begin
                    w_capture   = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirect_valid && redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output can be registered
    always_comb begin
        w_flush_nxt          = (w_state_nxt == ST_FLUSH);
        w_busy_nxt           = (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_REDIRECT);
        w_redirect_valid_nxt = (w_state_nxt == ST_REDIRECT);
    end

    // Registered control outputs and the redirect payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush          <= 1'b0;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            r_redirect     <= '0;
        end else begin
            flush          <= w_flush_nxt;
            busy           <= w_busy_nxt;
            redirect_valid <= w_redirect_valid_nxt;
            // Pending target is frozen during FLUSH/REDIRECT, so the offered PC stays stable
            if (w_redirect_valid_nxt) begin
                r_redirect <= r_pend;
            end
        end
    end

    // Oldest pending mispredict: ROB id and corrected target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_rob_id <= '0;
            r_pend        <= '0;
        end else if (w_capture) begin
            r_pend_rob_id <= br_rob_id;
            r_pend.pc     <= br_target_address;
        end
    end

    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt         <= '0;
            perf_mispredict_cnt <= '0;
        end else begin
            if (w_br_accept) begin
                perf_br_cnt <= perf_br_cnt + 32'd1;
            end
            if (r_state == ST_FLUSH) begin
                perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
            end
        end
    end

endmodule : br_recovery_ctrl
`default_nettype wire
